// File: rtl/led_blinker_pkg.sv
// Shared encodings for the multi-channel LED blinker: channel states, modes,
// and rate-select indices.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  localparam logic [1:0] RATE_0 = 2'd0;
  localparam logic [1:0] RATE_1 = 2'd1;
  localparam logic [1:0] RATE_2 = 2'd2;
  localparam logic [1:0] RATE_3 = 2'd3;

endpackage

// File: rtl/led_blinker_channel.sv
// One LED driver: IDLE/RUN/BURST state machine, half-period counter,
// remaining-blink count and registered LED output.
module led_blinker_channel #(
  parameter int CNT_W   = 32,
  parameter int C_RATE0 = 10,
  parameter int C_RATE1 = 20,
  parameter int C_RATE2 = 50,
  parameter int C_RATE3 = 100,
  parameter int BL_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            sync,
  input  logic [1:0]      rate_sel,
  input  logic            mode,
  input  logic            start,
  input  logic [BL_W-1:0] burst_len,
  output logic            led,
  output logic            busy,
  output logic            done
);
  import led_blinker_pkg::*;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BL_W-1:0]   rem_q, rem_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  lim_m1;
  logic              terminal;

  // Rate is sampled live so a lower rate ends the current half-period at once.
  always_comb begin
    unique case (rate_sel)
      RATE_0:  lim_m1 = CNT_W'(C_RATE0 - 1);
      RATE_1:  lim_m1 = CNT_W'(C_RATE1 - 1);
      RATE_2:  lim_m1 = CNT_W'(C_RATE2 - 1);
      default: lim_m1 = CNT_W'(C_RATE3 - 1);
    endcase
  end

  assign terminal = (cnt_q >= lim_m1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    led_d   = led_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        led_d = 1'b0;
        if (enable && mode == MODE_CONT) begin
          state_d = ST_RUN;
          led_d   = 1'b1;
        end else if (enable && mode == MODE_BURST && start) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BURST;
            rem_d   = burst_len;
            led_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!enable || mode == MODE_BURST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          led_d   = 1'b0;
        end else if (sync) begin
          cnt_d = '0;
          led_d = 1'b1;
        end else if (terminal) begin
          cnt_d = '0;
          led_d = ~led_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BURST: begin
        // Abort beats both sync and completion; sync beats a terminal edge.
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rem_d   = '0;
          led_d   = 1'b0;
        end else if (sync) begin
          cnt_d = '0;
          led_d = 1'b1;
        end else if (terminal) begin
          cnt_d = '0;
          if (led_q) begin
            led_d = 1'b0;
            rem_d = rem_q - BL_W'(1);
            if (rem_q == BL_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            led_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rem_d   = '0;
        led_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/led_blinker_multi.sv
// N_CH independent LED blinkers sharing enable, sync and burst length.
module led_blinker_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int C_RATE0 = 10,
  parameter int C_RATE1 = 20,
  parameter int C_RATE2 = 50,
  parameter int C_RATE3 = 100,
  parameter int BL_W    = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_sync,
  input  logic [2*N_CH-1:0] i_rate_sel,
  input  logic [N_CH-1:0]   i_mode,
  input  logic [N_CH-1:0]   i_start,
  input  logic [BL_W-1:0]   i_burst_len,
  output logic [N_CH-1:0]   o_led_drive,
  output logic [N_CH-1:0]   o_busy,
  output logic [N_CH-1:0]   o_done
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    led_blinker_channel #(
      .CNT_W  (CNT_W),
      .C_RATE0(C_RATE0),
      .C_RATE1(C_RATE1),
      .C_RATE2(C_RATE2),
      .C_RATE3(C_RATE3),
      .BL_W   (BL_W)
    ) u_ch (
      .clk      (i_clock),
      .rst_n    (i_reset_n),
      .enable   (i_enable),
      .sync     (i_sync),
      .rate_sel (i_rate_sel[2*k +: 2]),
      .mode     (i_mode[k]),
      .start    (i_start[k]),
      .burst_len(i_burst_len),
      .led      (o_led_drive[k]),
      .busy     (o_busy[k]),
      .done     (o_done[k])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Self-checking bench for led_blinker_multi: expectations are queued with the
// edge number they apply to and compared on the following falling edge.
module tb_led_blinker_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sync;
  logic [7:0] rate_sel;
  logic [3:0] mode, start;
  logic [7:0] blen;
  logic [3:0] led, busy, done;

  led_blinker_multi #(
    .N_CH(4), .CNT_W(32), .C_RATE0(10), .C_RATE1(20),
    .C_RATE2(50), .C_RATE3(100), .BL_W(8)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_enable   (en),
    .i_sync     (sync),
    .i_rate_sel (rate_sel),
    .i_mode     (mode),
    .i_start    (start),
    .i_burst_len(blen),
    .o_led_drive(led),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  localparam int SIG_LED = 0, SIG_BUSY = 1, SIG_DONE = 2;

  typedef struct {
    int    cyc;
    int    sig;
    int    ch;
    logic  val;
    string nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] rs;
    int         half;
  } rate_vec_t;
  rate_vec_t tbl[4];

  task automatic expect_at(input int c, input string nm, input int sig, input int ch, input logic v);
    exp_t e;
    e.cyc = c; e.sig = sig; e.ch = ch; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  function automatic logic pick(input int sig, input int ch);
    if (sig == SIG_LED)  return led[ch];
    if (sig == SIG_BUSY) return busy[ch];
    return done[ch];
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks = checks + 1;
        if (pick(sb[i].sig, sb[i].ch) !== sb[i].val) begin
          errors = errors + 1;
          $display("FAIL %s edge %0d ch%0d got %b want %b", sb[i].nm, cyc, sb[i].ch,
                   pick(sb[i].sig, sb[i].ch), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, s, y, t;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; rate_sel = '0;
    mode = '0; start = '0; blen = '0;

    // Reset held with inputs churning
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_hold", {led, busy, done}, 12'h000);
      en = 1'($urandom); sync = 1'($urandom); mode = 4'($urandom);
      start = 4'($urandom); rate_sel = 8'($urandom); blen = 8'($urandom);
    end
    @(negedge clk);
    en = 1'b0; sync = 1'b0; start = '0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {led, busy, done}, 12'h000);
      mode = 4'($urandom);
    end

    // Continuous blink, each channel on its own rate from the table
    tbl[0] = '{2'd0, 10};
    tbl[1] = '{2'd1, 20};
    tbl[2] = '{2'd2, 50};
    tbl[3] = '{2'd3, 100};
    tick();
    for (int k = 0; k < 4; k++) rate_sel[2*k +: 2] = tbl[k].rs;
    mode = 4'b0000; en = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      expect_at(e,                   "run_entry_led", SIG_LED,  k, 1'b1);
      expect_at(e,                   "run_busy",      SIG_BUSY, k, 1'b1);
      expect_at(e + tbl[k].half - 1, "run_hi_end",    SIG_LED,  k, 1'b1);
      expect_at(e + tbl[k].half,     "run_fall",      SIG_LED,  k, 1'b0);
      expect_at(e + 2*tbl[k].half - 1, "run_lo_end",  SIG_LED,  k, 1'b0);
      expect_at(e + 2*tbl[k].half,   "run_rise",      SIG_LED,  k, 1'b1);
    end
    wait_until(e + 202);

    // Burst of 3 on ch1; a second start mid-burst must be ignored
    tick(); en = 1'b0;
    tick(); en = 1'b1; mode = 4'b0010; rate_sel = 8'h00;
    tick(); blen = 8'd3; start = 4'b0010;
    s = cyc + 1;
    expect_at(s,      "burst_entry", SIG_LED,  1, 1'b1);
    expect_at(s + 9,  "burst_p1_hi", SIG_LED,  1, 1'b1);
    expect_at(s + 10, "burst_p1_lo", SIG_LED,  1, 1'b0);
    expect_at(s + 20, "burst_p2_hi", SIG_LED,  1, 1'b1);
    expect_at(s + 30, "burst_p2_lo", SIG_LED,  1, 1'b0);
    expect_at(s + 40, "burst_p3_hi", SIG_LED,  1, 1'b1);
    expect_at(s + 49, "burst_p3_end", SIG_LED, 1, 1'b1);
    expect_at(s + 49, "burst_no_early_done", SIG_DONE, 1, 1'b0);
    expect_at(s + 49, "burst_busy", SIG_BUSY, 1, 1'b1);
    expect_at(s + 50, "burst_done", SIG_DONE, 1, 1'b1);
    expect_at(s + 50, "burst_led_off", SIG_LED, 1, 1'b0);
    expect_at(s + 50, "burst_idle", SIG_BUSY, 1, 1'b0);
    expect_at(s + 51, "burst_done_pulse", SIG_DONE, 1, 1'b0);
    expect_at(s + 60, "burst_stays_off", SIG_LED, 1, 1'b0);
    tick(); start = '0; blen = 8'd7;
    wait_until(s + 14); start = 4'b0010;
    tick(); start = '0;
    wait_until(s + 62);

    // Lowering the rate mid-count on ch2
    tick(); en = 1'b0; mode = 4'b0000; rate_sel = 8'b00_11_00_00;
    tick(); en = 1'b1;
    e = cyc + 1;
    expect_at(e + 60, "rate_drop_before", SIG_LED, 2, 1'b1);
    expect_at(e + 61, "rate_drop_toggle", SIG_LED, 2, 1'b0);
    expect_at(e + 70, "rate_drop_lo",     SIG_LED, 2, 1'b0);
    expect_at(e + 71, "rate_drop_rise",   SIG_LED, 2, 1'b1);
    expect_at(e + 81, "rate_drop_fall",   SIG_LED, 2, 1'b0);
    wait_until(e + 60); rate_sel[5:4] = 2'd0;
    wait_until(e + 85);

    // Sync aligns ch0 and ch3 that started 8 clocks apart
    tick(); en = 1'b0;
    tick(); en = 1'b1; rate_sel = 8'b01_00_00_01; mode = 4'b1000;
    e = cyc + 1;
    y = e + 25;
    expect_at(y - 1,  "skew_ch0",   SIG_LED, 0, 1'b0);
    expect_at(y - 1,  "skew_ch3",   SIG_LED, 3, 1'b1);
    for (int k = 0; k < 4; k += 3) begin
      expect_at(y,      "sync_hi",    SIG_LED, k, 1'b1);
      expect_at(y + 19, "sync_hi_end", SIG_LED, k, 1'b1);
      expect_at(y + 20, "sync_fall",  SIG_LED, k, 1'b0);
      expect_at(y + 40, "sync_rise",  SIG_LED, k, 1'b1);
    end
    wait_until(e + 7); mode = 4'b0000;
    wait_until(y - 1); sync = 1'b1;
    tick(); sync = 1'b0;
    wait_until(y + 42);

    // Sync coincident with a burst terminal edge: no decrement
    tick(); en = 1'b0;
    tick(); en = 1'b1; mode = 4'b0010; rate_sel = 8'h00;
    tick(); blen = 8'd1; start = 4'b0010;
    s = cyc + 1;
    expect_at(s + 10, "sync_term_led",    SIG_LED,  1, 1'b1);
    expect_at(s + 10, "sync_term_nodone", SIG_DONE, 1, 1'b0);
    expect_at(s + 20, "sync_term_done",   SIG_DONE, 1, 1'b1);
    expect_at(s + 20, "sync_term_off",    SIG_LED,  1, 1'b0);
    expect_at(s + 20, "sync_term_idle",   SIG_BUSY, 1, 1'b0);
    tick(); start = '0;
    wait_until(s + 9); sync = 1'b1;
    tick(); sync = 1'b0;
    wait_until(s + 22);

    // Enable falls on the completing edge: abort, no done
    tick(); blen = 8'd1; start = 4'b0010;
    s = cyc + 1;
    expect_at(s + 9,  "abort_pre_led",  SIG_LED,  1, 1'b1);
    expect_at(s + 10, "abort_led",      SIG_LED,  1, 1'b0);
    expect_at(s + 10, "abort_busy",     SIG_BUSY, 1, 1'b0);
    expect_at(s + 10, "abort_nodone",   SIG_DONE, 1, 1'b0);
    expect_at(s + 11, "abort_nodone2",  SIG_DONE, 1, 1'b0);
    tick(); start = '0;
    wait_until(s + 9); en = 1'b0;
    wait_until(s + 12);

    // Zero-length burst: done on the start edge, LED untouched
    en = 1'b1; mode = 4'b0010; blen = 8'd0; start = 4'b0010;
    t = cyc + 1;
    expect_at(t,     "zero_done",     SIG_DONE, 1, 1'b1);
    expect_at(t,     "zero_led",      SIG_LED,  1, 1'b0);
    expect_at(t,     "zero_busy",     SIG_BUSY, 1, 1'b0);
    expect_at(t + 1, "zero_done_end", SIG_DONE, 1, 1'b0);
    expect_at(t + 1, "zero_led2",     SIG_LED,  1, 1'b0);
    tick(); start = '0;
    wait_until(t + 3);

    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s never compared (edge %0d)", sb[i].nm, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blinker_multi.md
Name: led_blinker_multi

Overview:
- Multi-channel successor to the single-LED blinker. N_CH independent LED drivers.
- Each channel selects one of four blink rates and runs in one of two modes: continuous blink, or a burst of a programmed number of blinks followed by a done pulse.
- A global sync input phase-aligns all running channels.
- Sits between board switches/control logic and the LED pins.

Parameters:
- N_CH, 4, number of LED channels (>=1).
- CNT_W, 32, half-period counter width; must hold the largest C_RATEx-1.
- C_RATE0, 10, half-period in clocks for rate select 0 (>=1).
- C_RATE1, 20, half-period for rate select 1.
- C_RATE2, 50, half-period for rate select 2.
- C_RATE3, 100, half-period for rate select 3.
- BL_W, 8, burst-length width.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  global enable; low forces all channels to IDLE.
- i_sync  in  1  single-cycle pulse: phase-align all active channels.
- i_rate_sel  in  2*N_CH  per-channel rate index; channel k uses bits [2k+1:2k].
- i_mode  in  N_CH  per-channel mode: 0 = continuous, 1 = burst.
- i_start  in  N_CH  per-channel burst start pulse.
- i_burst_len  in  BL_W  shared burst length, sampled on start.
- o_led_drive  out  N_CH  LED drive, registered.
- o_busy  out  N_CH  channel in RUN or BURST.
- o_done  out  N_CH  one-cycle pulse at burst completion.

Behaviour:
- Reset: all states IDLE; counters 0; remaining count 0; o_led_drive, o_busy and o_done all 0. Reset takes effect asynchronously and is released synchronously to i_clock.
- Per-channel states:
  - IDLE: LED 0, counter 0.
  - RUN: continuous blink.
  - BURST: counted blink.
- Transitions:
  - IDLE->RUN when i_enable=1 and mode=0.
  - IDLE->BURST on i_start=1 with i_enable=1 and mode=1; loads remaining = i_burst_len.
  - RUN->IDLE when i_enable=0 or mode becomes 1.
  - BURST->IDLE when i_enable=0 (abort, no o_done) or on burst completion.
- Entry edge into RUN or BURST: counter=0, LED=1.
- Counting in RUN/BURST:
  - Counter increments each clock.
  - Terminal when counter >= limit-1, where limit = C_RATE[rate_sel] sampled live.
  - At terminal: counter->0 and LED toggles.
  - LED period is therefore 2*limit clocks at 50% duty.
  - Lowering rate_sel mid-count terminates at the next cycle; no wrap-around.
  - C_RATEx=1 toggles every clock.
- Burst completion:
  - Each terminal edge where LED goes 1->0 decrements remaining.
  - When remaining reaches 0 on such an edge: state->IDLE, LED 0, o_done=1 for that cycle.
  - Total burst length is (2N-1)*limit clocks from the start edge to the done edge.
- i_burst_len=0: IDLE->IDLE, no blink, o_done pulses on the clock after i_start.
- i_start during BURST or RUN is ignored. i_start with mode=0 is ignored.
- i_sync in RUN/BURST: counter->0 and LED->1 on the same edge; state and remaining are unchanged. i_sync in IDLE has no effect. i_sync coincident with terminal: sync wins, no decrement.
- Simultaneous i_enable falling and terminal: abort wins; no o_done.
- o_busy = (state != IDLE), registered with the state.
- Channels are fully independent except for the shared i_enable, i_sync and i_burst_len.
- Reset asserted mid-burst: immediate IDLE; no o_done.

Decomposition:
- Shared package/include led_blinker_pkg:
  - State encodings ST_IDLE/ST_RUN/ST_BURST (2-bit).
  - Mode constants MODE_CONT=0, MODE_BURST=1.
  - Rate index constants.
- Sub-module led_blinker_channel:
  - Contains one state machine, counter, remaining count and LED flop.
  - Takes the four C_RATEx parameters.
- Top level instantiates led_blinker_channel N_CH times via generate and slices the buses.

Test Plan:
- Hold i_reset_n=0 for 5 clocks with inputs toggling -> all outputs 0 throughout. After release with i_enable=0 -> outputs stay 0.
- i_enable=1, ch0 mode=0, rate_sel=0 (C=10) -> LED0 goes 1 at the enable edge, then toggles every 10 clocks. o_busy0=1. Other channels, also mode 0, blink at their own rates.
- ch1 mode=1, i_burst_len=3, rate 0, pulse start -> exactly 3 high pulses of 10 clocks. o_done1 pulses at clock 50 after start. LED1=0 and o_busy1=0 thereafter. A second start mid-burst is ignored.
- ch2 running at rate 3 (C=100), counter at 60, rate_sel->0 -> toggle on the next clock, then every 10.
- Channels 0 and 3 at rate 1 with skewed phase; pulse i_sync -> both LEDs 1 on the same edge and toggle together 20 clocks later.
- Burst in progress, drop i_enable -> IDLE next edge, LED 0, no o_done. Then i_burst_len=0 with start -> o_done one clock after start, no LED activity.
